// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
  localparam int WORD_BYTES = 4;
  localparam int LANES = 4;
  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [LANES-1:0] lanes;
    logic             is_write;
  } dmem_req_t;
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: DEPTHx32 word array with per-lane writes and a registered read.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             en,
  input  logic             we,
  input  logic [LANES-1:0] lanes,
  input  logic [AW-1:0]    idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++)
          if (lanes[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end else rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time data-memory responder with programmable wait states.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  input  logic [31:0]      io_req_bits_addrRequest,
  input  logic [31:0]      io_req_bits_dataRequest,
  input  logic [LANES-1:0] io_req_bits_activeByteLane,
  input  logic             io_req_bits_isWrite,
  output logic             io_rsp_valid,
  output logic [31:0]      io_rsp_bits_dataResponse,
  output logic             io_rsp_bits_error
);
  localparam int AW = $clog2(DEPTH);
  dmem_state_e state;
  logic [3:0]  cnt;
  dmem_req_t   req_in, req_q, cur;
  logic        err_q, in_range, go_resp;
  logic [31:0] off, rdata;
  assign req_in = '{addr: io_req_bits_addrRequest, data: io_req_bits_dataRequest,
                    lanes: io_req_bits_activeByteLane, is_write: io_req_bits_isWrite};
  // With zero wait states the array is accessed on the accept edge, before the latch is loaded.
  assign cur      = (state == IDLE) ? req_in : req_q;
  assign off      = cur.addr - BASE_ADDR;
  assign in_range = (off >> 2) < 32'(DEPTH);
  assign go_resp  = reset && ((state == IDLE && io_req_valid && WAIT_STATES == 0) ||
                              (state == WAIT && cnt == 4'd1));
  dmem_bank #(.DEPTH(DEPTH)) u_bank (
    .clock (clock),
    .en    (go_resp && in_range),
    .we    (cur.is_write),
    .lanes (cur.lanes),
    .idx   (off[AW+1:2]),
    .wdata (cur.data),
    .rdata (rdata)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state                    <= IDLE;
      cnt                      <= '0;
      req_q                    <= '0;
      err_q                    <= 1'b0;
      io_rsp_valid             <= 1'b0;
      io_rsp_bits_dataResponse <= '0;
      io_rsp_bits_error        <= 1'b0;
    end else begin
      io_rsp_valid             <= 1'b0;
      io_rsp_bits_dataResponse <= '0;
      io_rsp_bits_error        <= 1'b0;
      case (state)
        IDLE: if (io_req_valid) begin
          req_q <= req_in;
          cnt   <= 4'(WAIT_STATES);
          state <= (WAIT_STATES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state                    <= IDLE;
          io_rsp_valid             <= 1'b1;
          io_rsp_bits_error        <= err_q;
          io_rsp_bits_dataResponse <= (err_q || req_q.is_write) ? '0 : rdata;
        end
        default: state <= IDLE;
      endcase
      if (go_resp) err_q <= !in_range;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of three responder configurations against a word-array model.
module tb_dmem_responder;
  localparam int NI = 3;
  logic        clock = 1'b0, reset = 1'b0;
  logic        req_valid [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_data  [NI];
  logic [3:0]  req_lanes [NI];
  logic        req_wr    [NI];
  logic        rsp_valid [NI];
  logic [31:0] rsp_data  [NI];
  logic        rsp_err   [NI];
  logic [31:0] mdl   [NI][1024];
  bit          known [NI][1024];
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  function automatic int ws(int k);
    return k == 0 ? 0 : (k == 1 ? 1 : 3);
  endfunction
  function automatic logic [31:0] base(int k);
    return k == 2 ? 32'h0000_2000 : 32'h0;
  endfunction
  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DEPTH(1024),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3)),
      .BASE_ADDR(g == 2 ? 32'h0000_2000 : 32'h0)
    ) u_dut (
      .clock                      (clock),
      .reset                      (reset),
      .io_req_valid               (req_valid[g]),
      .io_req_bits_addrRequest    (req_addr[g]),
      .io_req_bits_dataRequest    (req_data[g]),
      .io_req_bits_activeByteLane (req_lanes[g]),
      .io_req_bits_isWrite        (req_wr[g]),
      .io_rsp_valid               (rsp_valid[g]),
      .io_rsp_bits_dataResponse   (rsp_data[g]),
      .io_rsp_bits_error          (rsp_err[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // One full request: drive at a negedge, wait for the pulse, compare with the model.
  task automatic xact(input int k, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] ln, input logic wr, output logic [31:0] rd);
    logic [31:0] off, exp_d;
    bit inr, got;
    int idx, cyc;
    off   = a - base(k);
    inr   = off < 32'd4096;
    idx   = int'(off[11:2]);
    exp_d = (inr && !wr) ? mdl[k][idx] : 32'h0;
    if (inr && wr) begin
      for (int i = 0; i < 4; i++) if (ln[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
      if (ln == 4'hF) known[k][idx] = 1'b1;
    end
    req_addr[k] = a; req_data[k] = d; req_lanes[k] = ln; req_wr[k] = wr; req_valid[k] = 1'b1;
    got = 1'b0; cyc = 0;
    while (!got && cyc < ws(k) + 6) begin
      @(negedge clock);
      cyc++;
      got = rsp_valid[k];
    end
    req_valid[k] = 1'b0;
    rd = rsp_data[k];
    check($sformatf("latency i%0d a%h", k, a), 32'(cyc), 32'(ws(k) + 2));
    if (got) begin
      check($sformatf("error i%0d a%h", k, a), 32'(rsp_err[k]), 32'(!inr));
      check($sformatf("data i%0d a%h", k, a), rsp_data[k], exp_d);
    end
    @(negedge clock);
    check($sformatf("one_pulse i%0d", k), 32'(rsp_valid[k]), 32'h0);
  endtask
  initial begin
    logic [31:0] rd, a;
    int n, idx, pulses;
    bit oob, wr;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; req_data[k] = '0; req_lanes[k] = '0; req_wr[k] = 1'b0;
    end
    repeat (2) @(negedge clock);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_valid i%0d", k), 32'(rsp_valid[k]), 32'h0);
      check($sformatf("rst_data i%0d", k), rsp_data[k], 32'h0);
      check($sformatf("rst_error i%0d", k), 32'(rsp_err[k]), 32'h0);
    end
    reset = 1'b1;
    xact(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, rd);
    xact(1, 32'h10, 32'h0, 4'h0, 1'b0, rd);
    check("rd_deadbeef", rd, 32'hDEAD_BEEF);
    xact(1, 32'h14, 32'h1122_3344, 4'hF, 1'b1, rd);
    xact(1, 32'h14, 32'hAABB_CCDD, 4'b0101, 1'b1, rd);
    xact(1, 32'h17, 32'h0, 4'h0, 1'b0, rd);
    check("merge", rd, 32'h11BB_33DD);
    xact(1, 32'h0, 32'h600D_0000, 4'hF, 1'b1, rd);
    xact(1, 32'h1000, 32'h0, 4'hF, 1'b0, rd);
    xact(1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b1, rd);
    xact(1, 32'h0, 32'h0, 4'hF, 1'b0, rd);
    check("oob_no_write", rd, 32'h600D_0000);
    xact(2, 32'h1FFC, 32'h0, 4'hF, 1'b0, rd);
    xact(1, 32'h20, 32'h1234_5678, 4'hF, 1'b1, rd);
    xact(1, 32'h20, 32'hFFFF_FFFF, 4'h0, 1'b1, rd);
    xact(1, 32'h20, 32'h0, 4'h0, 1'b0, rd);
    check("lanes0", rd, 32'h1234_5678);
    // Zero wait states with valid held: a pulse every other cycle, one per request.
    req_addr[0] = 32'h40; req_data[0] = 32'hC0DE_0000; req_lanes[0] = 4'hF; req_wr[0] = 1'b1;
    req_valid[0] = 1'b1;
    n = 0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clock);
      check($sformatf("hold s%0d", s), 32'(rsp_valid[0]), 32'(s % 2));
      if (rsp_valid[0]) begin
        mdl[0][req_addr[0][11:2]] = req_data[0];
        known[0][req_addr[0][11:2]] = 1'b1;
        n++;
        if (n == 3) req_valid[0] = 1'b0;
        else begin
          req_addr[0] = req_addr[0] + 32'd4;
          req_data[0] = 32'hC0DE_0000 + 32'(n);
        end
      end
    end
    @(negedge clock);
    check("hold_tail", 32'(rsp_valid[0]), 32'h0);
    for (int i = 0; i < 3; i++) xact(0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, 1'b0, rd);
    check("hold_last", rd, 32'hC0DE_0002);
    // Reset in WAIT aborts the pending write and keeps earlier contents.
    xact(2, 32'h200C, 32'h0BAD_F00D, 4'hF, 1'b1, rd);
    req_addr[2] = 32'h200C; req_data[2] = 32'h5555_5555; req_lanes[2] = 4'hF; req_wr[2] = 1'b1;
    req_valid[2] = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    req_valid[2] = 1'b0;
    #1;
    check("abort_valid", 32'(rsp_valid[2]), 32'h0);
    check("abort_data", rsp_data[2], 32'h0);
    check("abort_error", 32'(rsp_err[2]), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clock);
      if (rsp_valid[2]) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'h0);
    xact(2, 32'h200C, 32'h0, 4'h0, 1'b0, rd);
    check("abort_keep", rd, 32'h0BAD_F00D);
    for (int k = 0; k < NI; k++)
      for (int t = 0; t < 50; t++) begin
        idx = $urandom_range(0, 15);
        oob = $urandom_range(0, 7) == 0;
        if (oob) a = $urandom_range(0, 1) ? base(k) + 32'h1000 + 32'(idx * 4) : base(k) - 32'd4 - 32'(idx * 4);
        else a = base(k) + 32'(idx * 4) + 32'($urandom_range(0, 3));
        wr = $urandom_range(0, 1) == 1;
        if (!oob && !known[k][idx]) wr = 1'b1;
        xact(k, a, $urandom, wr ? 4'($urandom_range(0, 15)) : 4'hF, wr, rd);
      end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
